j_stlatchn: RTL
===============

Name: j_stlatchn

Overview:
- Parametrised, multi-channel successor to the single-bit loadable latch with asynchronous clear.
- Holds NCH registers, each WIDTH bits wide, with per-channel load.
- Optional double-buffering: writes land in a staging register and transfer to the active register only at a commit handshake qualified by a safe-point strobe.
- Used in Jerry wherever control values must change atomically, e.g. DSP/DAC configuration updated at sample boundaries.

Parameters:
- WIDTH, 16, bits per channel (1..32).
- NCH, 4, number of channels (1..16).
- CHW, 2, width of channel index; must satisfy 2^CHW >= NCH.
- STAGED, 1, 0 = direct mode (write loads active register), 1 = double-buffered mode.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resl  in  1  asynchronous active-low reset; clears all state immediately.
- wr_en  in  1  load strobe, one write per cycle.
- wr_ch  in  CHW  target channel.
- wr_d  in  WIDTH  write data.
- commit_req  in  1  request to transfer pending staged values; level, held until ack.
- safe  in  1  safe-point strobe; a commit may only occur in a cycle where safe=1.
- q  out  NCH*WIDTH  active registers, channel i at bits [i*WIDTH +: WIDTH]; registered.
- d1  out  WIDTH  next value of channel wr_ch: wr_d if wr_en, else active[wr_ch]; combinational.
- pend  out  NCH  per-channel staged-but-uncommitted flag; always 0 when STAGED=0.
- armed  out  1  commit request accepted, waiting for safe.
- commit_ack  out  1  one-cycle pulse in the cycle the transfer occurs.

Behaviour:
- Reset (resl=0, asynchronous): q=0, all staging registers=0, pend=0, armed=0, commit_ack=0, FSM=IDLE.
- Release of resl is synchronised by the user; the block takes no action on the deasserting edge itself.
- Writes:
  - A write with wr_ch >= NCH is ignored entirely.
  - STAGED=0: active[wr_ch] <= wr_d on the edge; visible on q in the next cycle. The commit FSM is inert: armed=0; commit_ack pulses for one cycle per commit_req rising edge, so handshakes still complete.
  - STAGED=1: stage[wr_ch] <= wr_d and pend[wr_ch] <= 1; q is unchanged.
- FSM (STAGED=1), states IDLE, ARMED, XFER:
  - IDLE -> ARMED when commit_req=1 and safe=0.
  - IDLE -> XFER when commit_req=1 and safe=1 (same-cycle commit).
  - ARMED -> XFER when safe=1; remains ARMED while safe=0.
  - XFER -> IDLE unconditionally, after one cycle.
  - In XFER: for every i with pend[i]=1, active[i] <= stage[i] and pend[i] <= 0; commit_ack=1 for that cycle only.
  - armed=1 exactly while in ARMED.
  - commit_ack is registered: it is high in the cycle after the edge that entered XFER, coincident with the new q values.
  - XFER with no pending channels still pulses commit_ack and leaves q unchanged.
  - commit_req still high after ack: a new commit cycle starts from IDLE. The requester must drop commit_req on ack to avoid repeats.
- Simultaneous events:
  - Write to channel k in the XFER cycle: the commit uses the previous stage[k]. The new value is stored in stage[k] and pend[k] stays 1 for the next commit.
  - Write while ARMED: included in the commit if it occurs before the XFER cycle.
  - Two writes to one channel before a commit: the last one wins.
- Reset mid-operation (any state): FSM returns to IDLE and staged data is discarded; no commit_ack is emitted.
- d1 reflects the active path only, even in STAGED mode; it matches the legacy latch's transparent mux output.

Test Plan:
- Reset: hold resl=0 with random inputs -> q=0, pend=0, armed=0, commit_ack=0; release -> stays 0 until the first write.
- Direct mode (STAGED=0): write ch2=16'hA5A5 -> q[47:32]=16'hA5A5 next cycle; d1=16'hA5A5 during the write cycle; commit_req pulse -> single commit_ack.
- Staged commit: write ch0=16'h1234 and ch3=16'hBEEF, q stays 0, pend=4'b1001; commit_req=1, safe=0 for 5 cycles -> armed=1, q unchanged; safe=1 -> commit_ack pulse, q ch0=16'h1234, ch3=16'hBEEF, pend=0.
- Collision: write ch1=16'h0001, then commit with safe=1 while writing ch1=16'h0002 in the XFER cycle -> q ch1=16'h0001, pend[1]=1; second commit -> q ch1=16'h0002.
- Out-of-range and empty commit: NCH=3, write wr_ch=3 -> no state change; commit with pend=0 -> commit_ack pulse, q unchanged.
- Mid-commit reset: in ARMED with pend=4'b0110, assert resl=0 -> q=0, pend=0, armed=0, no commit_ack afterwards.

Source files
------------

// File: rtl/j_stlatchn.sv
// j_stlatchn: multi-channel loadable register bank with optional
// double-buffering. Staged writes become visible on q only at a commit
// handshake that lands on a safe-point strobe, so grouped control values
// change atomically.

// One channel: active register plus optional staging register and pend flag.
module j_stlatchn_ch #(
    parameter int WIDTH  = 16,
    parameter int STAGED = 1
) (
    input  logic             clk,
    input  logic             resl,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_d,
    input  logic             xfer,
    output logic [WIDTH-1:0] act,
    output logic             pend
);
    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] stg_q, stg_d;
    logic             pend_q, pend_d;

    // Next state. The transfer reads the old stage value, so a write on the
    // transfer edge is kept in stage and stays pending for the next commit.
    always_comb begin
        act_d  = act_q;
        stg_d  = stg_q;
        pend_d = pend_q;
        if (STAGED == 0) begin
            if (wr) act_d = wr_d;
        end else begin
            if (xfer && pend_q) begin
                act_d  = stg_q;
                pend_d = 1'b0;
            end
            if (wr) begin
                stg_d  = wr_d;
                pend_d = 1'b1;
            end
        end
    end

    // Channel state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resl) begin
        if (!resl) begin
            act_q  <= '0;
            stg_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            stg_q  <= stg_d;
            pend_q <= pend_d;
        end
    end

    assign act  = act_q;
    assign pend = pend_q;
endmodule

module j_stlatchn #(
    parameter int WIDTH  = 16,
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int STAGED = 1
) (
    input  logic                 clk,
    input  logic                 resl,
    input  logic                 wr_en,
    input  logic [CHW-1:0]       wr_ch,
    input  logic [WIDTH-1:0]     wr_d,
    input  logic                 commit_req,
    input  logic                 safe,
    output logic [NCH*WIDTH-1:0] q,
    output logic [WIDTH-1:0]     d1,
    output logic [NCH-1:0]       pend,
    output logic                 armed,
    output logic                 commit_ack
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_XFER} state_t;

    state_t         state_q;
    logic           armed_q, ack_q, req_q;
    logic           xfer_go;
    logic [NCH-1:0] hit;

    // Channel decode; an index >= NCH matches nothing and is dropped.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NCH; i++)
            hit[i] = wr_en && (wr_ch == CHW'(i));
    end

    // Transfer happens on the edge that enters XFER, so q and commit_ack
    // change together in the following cycle.
    always_comb begin
        xfer_go = 1'b0;
        if (STAGED != 0)
            xfer_go = safe && ((state_q == S_IDLE && commit_req) || state_q == S_ARMED);
    end

    // Legacy transparent-mux view: write data if writing, else active value.
    always_comb begin
        d1 = '0;
        if (wr_en) d1 = wr_d;
        else
            for (int i = 0; i < NCH; i++)
                if (wr_ch == CHW'(i)) d1 = q[i*WIDTH +: WIDTH];
    end

    // Commit FSM with registered armed/ack; in direct mode only an ack per
    // commit_req rising edge is produced.
    always_ff @(posedge clk or negedge resl) begin
        if (!resl) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            ack_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            req_q   <= commit_req;
            armed_q <= 1'b0;
            ack_q   <= 1'b0;
            if (STAGED == 0) begin
                ack_q <= commit_req && !req_q;
            end else begin
                case (state_q)
                    S_IDLE: if (commit_req) begin
                        if (safe) begin
                            state_q <= S_XFER;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= S_ARMED;
                            armed_q <= 1'b1;
                        end
                    end
                    S_ARMED: if (safe) begin
                        state_q <= S_XFER;
                        ack_q   <= 1'b1;
                    end else begin
                        armed_q <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        j_stlatchn_ch #(.WIDTH(WIDTH), .STAGED(STAGED)) u_ch (
            .clk  (clk),
            .resl (resl),
            .wr   (hit[i]),
            .wr_d (wr_d),
            .xfer (xfer_go),
            .act  (q[i*WIDTH +: WIDTH]),
            .pend (pend[i])
        );
    end

    assign armed      = armed_q;
    assign commit_ack = ack_q;
endmodule
